// File: rtl/mmu_pkg.sv
// Shared MMU definitions: array geometry, datapath widths
// and the weight-loader FSM state encoding.
package mmu_pkg;

    localparam int MMU_DIM    = 4;
    localparam int MMU_DATA_W = 8;
    localparam int MMU_SUM_W  = 16;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_READ  = 3'd1,
        LD_SHIFT = 3'd2,
        LD_DRAIN = 3'd3,
        LD_DONE  = 3'd4
    } ld_state_t;

endpackage

// File: rtl/mmu_weight_loader.sv
// Weight-shift chain driver: reads DIM rows top-address-first and
// shifts them into the top row of the PE array, then drains.
module mmu_weight_loader
    import mmu_pkg::*;
#(
    parameter int DIM    = MMU_DIM,
    parameter int ADDR_W = 8,
    parameter int DRAIN  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [DIM*MMU_DATA_W-1:0] mem_rd_data,
    output logic [DIM*MMU_DATA_W-1:0] win,
    output logic [DIM-1:0]            wwrite,
    output logic                      busy,
    output logic                      done
);

    localparam int WW       = DIM * MMU_DATA_W;
    localparam int RW       = $clog2(DIM + 1);
    localparam int DW       = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;
    localparam int DRN_INIT = (DRAIN > 0) ? DRAIN - 1 : 0;

    ld_state_t         state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DW-1:0]     drn_q, drn_d;
    logic              vld_q, vld_d;
    logic              en_d;
    logic [ADDR_W-1:0] addr_d;
    logic [WW-1:0]     win_d;
    logic [DIM-1:0]    wwr_d;
    logic              busy_d;
    logic              done_d;

    // Next state and next values of every registered output.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drn_d   = drn_q;
        en_d    = mem_rd_en;
        addr_d  = mem_rd_addr;
        busy_d  = busy;
        done_d  = 1'b0;
        vld_d   = mem_rd_en;
        win_d   = vld_q ? mem_rd_data : win;
        wwr_d   = vld_q ? {DIM{1'b1}} : {DIM{1'b0}};

        unique case (state_q)
            LD_IDLE, LD_DONE: begin
                state_d = LD_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = LD_READ;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    addr_d  = base_addr + ADDR_W'(DIM - 1);
                    row_d   = RW'(DIM - 1);
                end
            end
            LD_READ: begin
                if (row_q == '0) begin
                    en_d    = 1'b0;
                    state_d = LD_SHIFT;
                end else begin
                    addr_d = mem_rd_addr - 1'b1;
                    row_d  = row_q - 1'b1;
                end
            end
            LD_SHIFT: begin
                // Last row still in the read pipe until vld drops.
                if (!vld_q) begin
                    if (DRAIN == 0) begin
                        state_d = LD_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = LD_DRAIN;
                        drn_d   = DW'(DRN_INIT);
                    end
                end
            end
            LD_DRAIN: begin
                if (drn_q == '0) begin
                    state_d = LD_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    drn_d = drn_q - 1'b1;
                end
            end
            default: begin
                state_d = LD_IDLE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
            end
        endcase
    end

    // State, counters, read-valid pipe and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LD_IDLE;
            row_q       <= '0;
            drn_q       <= '0;
            vld_q       <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            win         <= '0;
            wwrite      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            drn_q       <= drn_d;
            vld_q       <= vld_d;
            mem_rd_en   <= en_d;
            mem_rd_addr <= addr_d;
            win         <= win_d;
            wwrite      <= wwr_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_mmu_weight_loader.sv
// Directed bench for mmu_weight_loader: DRAIN=4 and DRAIN=0 builds,
// cycle-accurate traces checked against hand-derived timelines.
module tb_mmu_weight_loader;

    logic        clk = 1'b0;
    logic        reset, start, start2;
    logic [7:0]  base, base2;
    logic        rd_en, rd_en2;
    logic [7:0]  rd_addr, rd_addr2;
    logic [31:0] rd_data, rd_data2;
    logic [31:0] win, win2;
    logic [3:0]  wwr, wwr2;
    logic        busy, busy2, done, done2;
    logic [7:0]  mbase, mbase2;
    logic        neg;

    int cyc, errs, checks, T;

    logic        t_en   [0:255];
    logic [7:0]  t_addr [0:255];
    logic [3:0]  t_wwr  [0:255];
    logic [31:0] t_win  [0:255];
    logic        t_done [0:255];
    logic        t_busy [0:255];
    logic [3:0]  t_wwr2 [0:255];
    logic [31:0] t_win2 [0:255];
    logic        t_done2[0:255];
    logic        t_busy2[0:255];

    always #5 clk = ~clk;

    mmu_weight_loader #(.DIM(4), .ADDR_W(8), .DRAIN(4)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base),
        .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
        .win(win), .wwrite(wwr), .busy(busy), .done(done)
    );

    mmu_weight_loader #(.DIM(4), .ADDR_W(8), .DRAIN(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .base_addr(base2),
        .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2), .mem_rd_data(rd_data2),
        .win(win2), .wwrite(wwr2), .busy(busy2), .done(done2)
    );

    function automatic logic [31:0] row_word(logic [7:0] a, logic [7:0] b,
                                             logic n);
        logic [1:0]  r;
        logic [31:0] w;
        r = a[1:0] - b[1:0];
        for (int c = 0; c < 4; c++)
            w[8*c +: 8] = (n ? 8'h80 : 8'h00) + {2'b00, r, 4'h0} + 8'(c);
        return w;
    endfunction

    // Weight memories with one-cycle read latency; junk when not read.
    always @(posedge clk) begin
        rd_data  <= rd_en  ? row_word(rd_addr, mbase, neg)    : 32'hA5A5A5A5;
        rd_data2 <= rd_en2 ? row_word(rd_addr2, mbase2, 1'b0) : 32'h5A5A5A5A;
    end

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < 256) begin
            t_en[cyc]    = rd_en;
            t_addr[cyc]  = rd_addr;
            t_wwr[cyc]   = wwr;
            t_win[cyc]   = win;
            t_done[cyc]  = done;
            t_busy[cyc]  = busy;
            t_wwr2[cyc]  = wwr2;
            t_win2[cyc]  = win2;
            t_done2[cyc] = done2;
            t_busy2[cyc] = busy2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int cnt_en(int a, int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(t_en[i]);
        return n;
    endfunction

    function automatic int cnt_done(int a, int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(t_done[i]);
        return n;
    endfunction

    function automatic int cnt_wwr(int a, int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(t_wwr[i] != 4'h0);
        return n;
    endfunction

    logic [7:0] wrap_addr [0:3];

    initial begin
        cyc = 0; errs = 0; checks = 0;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        base = 8'h00; base2 = 8'h00;
        mbase = 8'h00; mbase2 = 8'h00; neg = 1'b0;
        wrap_addr[0] = 8'h01; wrap_addr[1] = 8'h00;
        wrap_addr[2] = 8'hFF; wrap_addr[3] = 8'hFE;
        repeat (3) step();
        chk("rst_en",   {31'd0, rd_en}, 32'd0);
        chk("rst_addr", {24'd0, rd_addr}, 32'd0);
        chk("rst_win",  win, 32'd0);
        chk("rst_wwr",  {28'd0, wwr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // 1: basic load, base 0x10
        T = cyc; base = 8'h10; mbase = 8'h10; start = 1'b1;
        step(); start = 1'b0;
        repeat (11) step();
        for (int k = 1; k <= 4; k++) begin
            chk("t1_en", {31'd0, t_en[T+k]}, 32'd1);
            chk("t1_addr", {24'd0, t_addr[T+k]}, {24'd0, 8'h14 - 8'(k)});
        end
        chk("t1_en_off", {31'd0, t_en[T+5]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t1_wwr", {28'd0, t_wwr[T+3+k]}, 32'hF);
            chk("t1_win0", {24'd0, t_win[T+3+k][7:0]},
                {24'd0, 8'h30 - 8'(16*k)});
        end
        chk("t1_wwr_pre", {28'd0, t_wwr[T+2]}, 32'h0);
        chk("t1_wwr_off", {28'd0, t_wwr[T+7]}, 32'h0);
        chk("t1_win_r3", t_win[T+3], 32'h33323130);
        chk("t1_win_hold", t_win[T+10], 32'h03020100);
        chk("t1_busy", {31'd0, t_busy[T+1]}, 32'd1);
        chk("t1_done_pre", {31'd0, t_done[T+10]}, 32'd0);
        chk("t1_done", {31'd0, t_done[T+11]}, 32'd1);
        chk("t1_busy_done", {31'd0, t_busy[T+11]}, 32'd0);

        // 2: start pulses while busy are dropped
        T = cyc; base = 8'h20; mbase = 8'h20; start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            start = (i == 2 || i == 8);
            base  = (i == 2 || i == 8) ? 8'h40 : 8'h20;
        end
        start = 1'b0; base = 8'h20;
        chk("t2_en_cnt", 32'(cnt_en(T+1, T+14)), 32'd4);
        chk("t2_done_cnt", 32'(cnt_done(T+1, T+14)), 32'd1);
        chk("t2_done", {31'd0, t_done[T+11]}, 32'd1);
        chk("t2_addr", {24'd0, t_addr[T+1]}, 32'h23);
        chk("t2_win_r0", t_win[T+6], 32'h03020100);

        // 3: back-to-back load from the done cycle
        T = cyc; base = 8'h30; mbase = 8'h30; start = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            step();
            start = (i == 11);
        end
        start = 1'b0;
        chk("t3_done1", {31'd0, t_done[T+11]}, 32'd1);
        chk("t3_en2", {31'd0, t_en[T+12]}, 32'd1);
        chk("t3_addr2", {24'd0, t_addr[T+12]}, 32'h33);
        chk("t3_gap", 32'(cnt_wwr(T+7, T+13)), 32'd0);
        chk("t3_wwr2", {28'd0, t_wwr[T+14]}, 32'hF);
        chk("t3_busy2", {31'd0, t_busy[T+12]}, 32'd1);
        chk("t3_done_mid", 32'(cnt_done(T+12, T+21)), 32'd0);
        chk("t3_done2", {31'd0, t_done[T+22]}, 32'd1);

        // 4: address wrap and negative weights
        T = cyc; base = 8'hFE; mbase = 8'hFE; neg = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        repeat (11) step();
        for (int k = 0; k < 4; k++)
            chk("t4_addr", {24'd0, t_addr[T+1+k]}, {24'd0, wrap_addr[k]});
        chk("t4_win_r3", t_win[T+3], 32'hB3B2B1B0);
        chk("t4_win_neg", {24'd0, t_win[T+6][7:0]}, 32'h80);
        chk("t4_win_r0", t_win[T+6], 32'h83828180);
        chk("t4_done", {31'd0, t_done[T+11]}, 32'd1);
        neg = 1'b0;

        // 5: reset mid-load, then clean restart
        T = cyc; base = 8'h50; mbase = 8'h50; start = 1'b1;
        step(); start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_en",   {31'd0, rd_en}, 32'd0);
        chk("t5_addr", {24'd0, rd_addr}, 32'd0);
        chk("t5_win",  win, 32'd0);
        chk("t5_wwr",  {28'd0, wwr}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        step();
        start = 1'b1;
        step(); start = 1'b0;
        repeat (11) step();
        chk("t5_pre_win", t_win[T+4], 32'h23222120);
        chk("t5_re_en", {31'd0, t_en[T+7]}, 32'd1);
        chk("t5_re_addr", {24'd0, t_addr[T+7]}, 32'h53);
        chk("t5_re_win", t_win[T+9], 32'h33323130);
        chk("t5_no_done", 32'(cnt_done(T+5, T+16)), 32'd0);
        chk("t5_re_done", {31'd0, t_done[T+17]}, 32'd1);

        // 6: DRAIN=0 build
        T = cyc; base2 = 8'h60; mbase2 = 8'h60; start2 = 1'b1;
        step(); start2 = 1'b0;
        repeat (10) step();
        chk("t6_wwr_first", {28'd0, t_wwr2[T+3]}, 32'hF);
        chk("t6_win_r3", t_win2[T+3], 32'h33323130);
        chk("t6_wwr_last", {28'd0, t_wwr2[T+6]}, 32'hF);
        chk("t6_done_pre", {31'd0, t_done2[T+6]}, 32'd0);
        chk("t6_done", {31'd0, t_done2[T+7]}, 32'd1);
        chk("t6_busy_done", {31'd0, t_busy2[T+7]}, 32'd0);
        chk("t6_wwr_off", {28'd0, t_wwr2[T+7]}, 32'h0);
        chk("t6_win_done", t_win2[T+7], 32'h03020100);
        chk("t6_done_once", {31'd0, t_done2[T+8]}, 32'd0);
        chk("t6_win_hold", t_win2[T+10], 32'h03020100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
